// File: rtl/port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : port_arbiter_if
// Purpose  : Handshake bundle between the RX requesters / TX unit and one
//            per-output-port switch arbiter.
// Signals  : reqs_in  [PORTS]      RX j requests this output (level)
//            acks_in  [PORTS]      completion ack to RX j (one-hot or zero)
//            req_out               request to TX to send the selected packet
//            ack_out               TX done for the current packet (level)
//            selected [PORT_BITS]  index of the granted RX (crossbar steer)
//            active                a grant is held, selected is valid
// Modports : master - the arbiter side; slave - the RX/TX environment side
// Revision : 1.0 - initial release
// ============================================================================
interface port_arbiter_if #(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8
);
    logic [PORTS-1:0]     reqs_in;
    logic [PORTS-1:0]     acks_in;
    logic                 req_out;
    logic                 ack_out;
    logic [PORT_BITS-1:0] selected;
    logic                 active;

    modport master (
        input  reqs_in,
        input  ack_out,
        output acks_in,
        output req_out,
        output selected,
        output active
    );

    modport slave (
        output reqs_in,
        output ack_out,
        input  acks_in,
        input  req_out,
        input  selected,
        input  active
    );
endinterface
`default_nettype wire

// File: rtl/port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : port_arbiter
// Purpose  : Per-output-port round-robin switch arbiter. Grants one RX
//            requester at a time, steers the crossbar with its index and
//            relays the TX completion back to it as a 4-phase req/ack.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset
//            bus    - port_arbiter_if.master (reqs_in, acks_in, req_out,
//                     ack_out, selected, active)
// Revision : 1.0 - initial release
// ============================================================================
module port_arbiter #(
    parameter int ID        = 0,
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    port_arbiter_if.master  bus
);

    // Elaboration-time sanity check on the parameter set.
    if (PORTS < 2 || ID < 0 || (PORT_BITS < 31 && PORTS > (1 << PORT_BITS))) begin : g_bad_params
        $error("port_arbiter %0d: illegal PORTS/PORT_BITS combination", ID);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [PORT_BITS-1:0] r_last;

    logic [PORT_BITS-1:0] w_winner;
    logic                 w_found;
    int                   w_cand;
    logic [PORTS-1:0]     w_sel_onehot;
    logic                 w_sel_req;

    // Round-robin scan starting just after the last winner. r_last < PORTS
    // and the offset is at most PORTS, so one conditional subtraction gives
    // an exact modulo for any PORTS, power of two or not.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int i = 1; i <= PORTS; i++) begin
            w_cand = int'(r_last) + i;
            if (w_cand >= PORTS) begin
                w_cand = w_cand - PORTS;
            end
            if (!w_found && bus.reqs_in[w_cand]) begin
                w_found  = 1'b1;
                w_winner = PORT_BITS'(w_cand);
            end
        end
    end

    // One-hot view of the held grant; avoids indexing with a PORT_BITS-wide
    // value that could exceed the request vector.
    always_comb begin
        w_sel_onehot = '0;
        for (int j = 0; j < PORTS; j++) begin
            w_sel_onehot[j] = (bus.selected == PORT_BITS'(j));
        end
    end

    assign w_sel_req = |(bus.reqs_in & w_sel_onehot);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last       <= PORT_BITS'(PORTS - 1);
            bus.acks_in  <= '0;
            bus.req_out  <= 1'b0;
            bus.selected <= '0;
            bus.active   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        bus.selected <= w_winner;
                        bus.active   <= 1'b1;
                        bus.req_out  <= 1'b1;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Request withdrawal is ignored here; only the TX ack
                    // completes the grant.
                    if (bus.ack_out) begin
                        bus.req_out <= 1'b0;
                        bus.acks_in <= w_sel_onehot;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Both sides must return to zero before the grant is freed.
                    if (!w_sel_req && !bus.ack_out) begin
                        bus.acks_in <= '0;
                        bus.active  <= 1'b0;
                        r_last      <= bus.selected;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    bus.acks_in <= '0;
                    bus.req_out <= 1'b0;
                    bus.active  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_arbiter
// Purpose  : Directed and randomised self-checking bench for port_arbiter
//            (PORTS=5, PORT_BITS=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_arbiter;

    localparam int PORTS     = 5;
    localparam int PORT_BITS = 8;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    port_arbiter_if #(.PORTS(PORTS), .PORT_BITS(PORT_BITS)) bus ();

    port_arbiter #(
        .ID        (0),
        .PORTS     (PORTS),
        .PORT_BITS (PORT_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.reqs_in = '0;
        bus.ack_out = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".active"},  32'(bus.active),  32'd0);
        check({tag, ".req_out"}, 32'(bus.req_out), 32'd0);
        check({tag, ".acks"},    32'(bus.acks_in), 32'd0);
    endtask

    int          order [6] = '{1, 2, 4, 1, 2, 4};
    int          waitc [PORTS];
    logic [PORTS-1:0] sampled;
    logic        prev_active;
    int          g;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.reqs_in = '0;
        bus.ack_out = 1'b0;

        // ---- 1: reset state and single packet on port 0
        do_reset();
        check_idle("rst");
        check("rst.sel", 32'(bus.selected), 32'd0);
        bus.reqs_in = 5'b00001;
        tick();
        check("t1.sel",     32'(bus.selected), 32'd0);
        check("t1.active",  32'(bus.active),   32'd1);
        check("t1.req_out", 32'(bus.req_out),  32'd1);
        bus.ack_out = 1'b1;
        tick();
        check("t1.acks",    32'(bus.acks_in),  32'h01);
        check("t1.req_off", 32'(bus.req_out),  32'd0);
        bus.reqs_in = '0;
        bus.ack_out = 1'b0;
        tick();
        check_idle("t1.end");
        check("t1.end.sel", 32'(bus.selected), 32'd0);

        // ---- 2: round-robin order with wrap 4 -> 1
        do_reset();
        bus.reqs_in = 5'b10110;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2.sel",    32'(bus.selected), 32'(order[k]));
            check("t2.active", 32'(bus.active),   32'd1);
            bus.ack_out = 1'b1;
            tick();
            check("t2.acks", 32'(bus.acks_in), 32'(1 << order[k]));
            bus.reqs_in[order[k]] = 1'b0;
            bus.ack_out = 1'b0;
            tick();
            check("t2.release", 32'(bus.active), 32'd0);
            bus.reqs_in[order[k]] = 1'b1;
        end
        bus.reqs_in = '0;

        // ---- 3: grant held while other requests change
        do_reset();
        bus.reqs_in = 5'b01000;
        tick();
        check("t3.sel", 32'(bus.selected), 32'd3);
        bus.reqs_in = 5'b00001;
        tick();
        tick();
        check("t3.hold.sel",  32'(bus.selected), 32'd3);
        check("t3.hold.act",  32'(bus.active),   32'd1);
        check("t3.hold.req",  32'(bus.req_out),  32'd1);
        bus.ack_out = 1'b1;
        tick();
        check("t3.acks",     32'(bus.acks_in),  32'h08);
        check("t3.acks.sel", 32'(bus.selected), 32'd3);
        bus.ack_out = 1'b0;
        tick();
        check("t3.release", 32'(bus.active), 32'd0);
        tick();
        check("t3.next.sel", 32'(bus.selected), 32'd0);
        check("t3.next.act", 32'(bus.active),   32'd1);
        bus.ack_out = 1'b1;
        tick();
        bus.reqs_in = '0;
        bus.ack_out = 1'b0;
        tick();

        // ---- 4: DONE held by ack_out after request dropped
        do_reset();
        bus.reqs_in = 5'b00100;
        tick();
        check("t4.sel", 32'(bus.selected), 32'd2);
        bus.ack_out = 1'b1;
        tick();
        check("t4.acks", 32'(bus.acks_in), 32'h04);
        bus.reqs_in = '0;
        tick();
        tick();
        check("t4.hold.act",  32'(bus.active),  32'd1);
        check("t4.hold.acks", 32'(bus.acks_in), 32'h04);
        bus.ack_out = 1'b0;
        tick();
        check_idle("t4.end");

        // ---- 5: asynchronous reset while BUSY
        do_reset();
        bus.reqs_in = 5'b00100;
        tick();
        check("t5.sel", 32'(bus.selected), 32'd2);
        reset = 1'b1;
        #1;
        check_idle("t5.async");
        check("t5.async.sel", 32'(bus.selected), 32'd0);
        bus.reqs_in = 5'b11111;
        tick();
        reset = 1'b0;
        tick();
        check("t5.after.sel", 32'(bus.selected), 32'd0);
        check("t5.after.act", 32'(bus.active),   32'd1);
        bus.ack_out = 1'b1;
        tick();
        bus.reqs_in = '0;
        bus.ack_out = 1'b0;
        tick();

        // ---- 6: random RX/TX traffic with invariant and fairness checks
        do_reset();
        for (int j = 0; j < PORTS; j++) waitc[j] = 0;
        prev_active = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            sampled = bus.reqs_in;
            check("r.onehot", 32'($onehot0(bus.acks_in)), 32'd1);
            if (!bus.active) begin
                check("r.idle.req",  32'(bus.req_out), 32'd0);
                check("r.idle.acks", 32'(bus.acks_in), 32'd0);
            end
            if (bus.active && !prev_active) begin
                g = int'(bus.selected);
                check("r.grant.valid", 32'(g < PORTS && sampled[g % PORTS]), 32'd1);
                for (int j = 0; j < PORTS; j++) begin
                    if (j == g) begin
                        waitc[j] = 0;
                    end else if (sampled[j]) begin
                        waitc[j]++;
                        check("r.starve", 32'(waitc[j] <= PORTS), 32'd1);
                    end else begin
                        waitc[j] = 0;
                    end
                end
            end
            prev_active = bus.active;
            // RX model: hold request until acked, then drop it.
            for (int j = 0; j < PORTS; j++) begin
                if (bus.acks_in[j]) begin
                    if ($urandom_range(0, 1) == 0) bus.reqs_in[j] = 1'b0;
                end else if (!bus.reqs_in[j]) begin
                    if ($urandom_range(0, 3) == 0) bus.reqs_in[j] = 1'b1;
                end
            end
            // TX model.
            if (bus.req_out) begin
                bus.ack_out = ($urandom_range(0, 1) == 0);
            end else if (bus.acks_in != '0) begin
                if (bus.ack_out && $urandom_range(0, 1) == 0) bus.ack_out = 1'b0;
            end else begin
                bus.ack_out = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
